// File: rtl/ps2_keymap.sv
// Run-time loadable PS/2 key table: each ps2_key event is scanned against every entry,
// one entry per clock, and each matching entry drives its button bit.

module ps2_keymap_entry (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       wr_code,
    input  logic       wr_flag,
    input  logic [7:0] data,
    input  logic       clear,
    input  logic       scan_sel,
    input  logic       ev_pressed,
    input  logic       ev_ext,
    input  logic [7:0] ev_code,
    output logic       button,
    output logic       match
);
    logic [7:0] code;
    logic       ext;
    logic       valid;

    // Code and ext bits deliberately survive reset; only valid is cleared.
    always_ff @(posedge clk_sys) begin
        if (wr_code) code <= data;
        if (wr_flag) ext  <= data[0];
    end

    always_ff @(posedge clk_sys) begin
        if (reset)        valid <= 1'b0;
        else if (wr_flag) valid <= data[7];
    end

    assign match = valid && (ext == ev_ext) && (code == ev_code);

    // Remapping an entry drops its button so a held key cannot stick on the old mapping.
    always_ff @(posedge clk_sys) begin
        if (reset)                    button <= 1'b0;
        else if (clear)               button <= 1'b0;
        else if (wr_code || wr_flag)  button <= 1'b0;
        else if (scan_sel && match)   button <= ev_pressed;
    end
endmodule

module ps2_keymap #(
    parameter int NUM_BUTTONS = 20,
    parameter int ADDR_W      = 7
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic                   map_wr,
    input  logic [ADDR_W-1:0]      map_addr,
    input  logic [7:0]             map_data,
    input  logic                   clear,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   busy,
    output logic                   done,
    output logic                   hit,
    output logic                   overflow
);
    localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUTTONS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } key_ev_t;

    logic                   old_tog;
    logic                   key_event;
    key_ev_t                pend;
    logic                   pend_vld;
    key_ev_t                ev;
    logic [1:0]             state;
    logic [IDX_W-1:0]       idx;
    logic                   hit_acc;
    logic                   load;
    logic                   cur_match;
    logic [NUM_BUTTONS-1:0] match_vec;
    logic [ADDR_W-1:0]      wr_entry;

    assign key_event = (ps2_key[10] != old_tog);
    assign load      = pend_vld && (state == S_IDLE || state == S_DONE);
    assign cur_match = (state == S_SCAN) && match_vec[idx];
    assign busy      = (state != S_IDLE);
    assign wr_entry  = map_addr >> 1;

    // Tracking the toggle through reset means a level held across reset release is not an event.
    always_ff @(posedge clk_sys) begin
        old_tog <= ps2_key[10];
    end

    // One-deep pending slot; the slot frees in the same cycle the FSM consumes it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (key_event && (!pend_vld || load)) begin
                pend     <= '{pressed: ps2_key[9], ext: ps2_key[8], code: ps2_key[7:0]};
                pend_vld <= 1'b1;
            end else begin
                if (load)      pend_vld <= 1'b0;
                if (key_event) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            hit_acc <= 1'b0;
            done    <= 1'b0;
            hit     <= 1'b0;
        end else begin
            done <= 1'b0;
            hit  <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (load) begin
                        ev      <= pend;
                        idx     <= '0;
                        hit_acc <= 1'b0;
                        state   <= S_SCAN;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (cur_match) hit_acc <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        hit   <= hit_acc || cur_match;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Out-of-range addresses never equal an entry index, so they fall through as no-ops.
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ent
        logic sel;
        assign sel = map_wr && (wr_entry == ADDR_W'(i));

        ps2_keymap_entry u_ent (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .wr_code    (sel && !map_addr[0]),
            .wr_flag    (sel && map_addr[0]),
            .data       (map_data),
            .clear      (clear),
            .scan_sel   ((state == S_SCAN) && (idx == IDX_W'(i))),
            .ev_pressed (ev.pressed),
            .ev_ext     (ev.ext),
            .ev_code    (ev.code),
            .button     (buttons[i]),
            .match      (match_vec[i])
        );
    end
endmodule
